// File: rtl/axi_rr_arbiter_if.sv
// axi_rr_arbiter_if: master-side (per-master vectors) and slave-side AXI4-Lite signals of the arbiter
interface axi_rr_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;
  logic [NUM_MASTERS*ADDR_W-1:0] m_araddr;
  logic [NUM_MASTERS-1:0]        m_arvalid;
  logic [NUM_MASTERS-1:0]        m_arready;
  logic [NUM_MASTERS*DATA_W-1:0] m_rdata;
  logic [NUM_MASTERS*2-1:0]      m_rresp;
  logic [NUM_MASTERS-1:0]        m_rvalid;
  logic [NUM_MASTERS-1:0]        m_rready;
  logic [NUM_MASTERS*ADDR_W-1:0] m_awaddr;
  logic [NUM_MASTERS-1:0]        m_awvalid;
  logic [NUM_MASTERS-1:0]        m_awready;
  logic [NUM_MASTERS*DATA_W-1:0] m_wdata;
  logic [NUM_MASTERS*STRB_W-1:0] m_wstrb;
  logic [NUM_MASTERS-1:0]        m_wvalid;
  logic [NUM_MASTERS-1:0]        m_wready;
  logic [NUM_MASTERS*2-1:0]      m_bresp;
  logic [NUM_MASTERS-1:0]        m_bvalid;
  logic [NUM_MASTERS-1:0]        m_bready;
  logic [ADDR_W-1:0]             s_araddr;
  logic                          s_arvalid;
  logic                          s_arready;
  logic [DATA_W-1:0]             s_rdata;
  logic [1:0]                    s_rresp;
  logic                          s_rvalid;
  logic                          s_rready;
  logic [ADDR_W-1:0]             s_awaddr;
  logic                          s_awvalid;
  logic                          s_awready;
  logic [DATA_W-1:0]             s_wdata;
  logic [STRB_W-1:0]             s_wstrb;
  logic                          s_wvalid;
  logic                          s_wready;
  logic [1:0]                    s_bresp;
  logic                          s_bvalid;
  logic                          s_bready;
  modport slave (
    input  m_araddr, m_arvalid, m_rready, m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready,
    input  s_arready, s_rdata, s_rresp, s_rvalid, s_awready, s_wready, s_bresp, s_bvalid,
    output m_arready, m_rdata, m_rresp, m_rvalid, m_awready, m_wready, m_bresp, m_bvalid,
    output s_araddr, s_arvalid, s_rready, s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready
  );
  modport master (
    output m_araddr, m_arvalid, m_rready, m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready,
    output s_arready, s_rdata, s_rresp, s_rvalid, s_awready, s_wready, s_bresp, s_bvalid,
    input  m_arready, m_rdata, m_rresp, m_rvalid, m_awready, m_wready, m_bresp, m_bvalid,
    input  s_araddr, s_arvalid, s_rready, s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready
  );
endinterface

// File: rtl/axi_rr_arbiter.sv
// axi_rr_arbiter: N-master to 1-slave AXI4-Lite round-robin arbiter, one transaction at a time
module axi_rr_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  localparam int STRB_W = DATA_W / 8,
  localparam int GW = NUM_MASTERS > 1 ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  axi_rr_arbiter_if.slave     bus,
  output logic [GW-1:0]       grant_id,
  output logic                busy
);
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR, WR_RESP} state_t;
  state_t state, state_n;
  logic [GW-1:0] ptr, ptr_n, grant_n, win, g_inc;
  logic aw_done, w_done, aw_n, w_n;
  logic [NUM_MASTERS-1:0] req;
  assign req = bus.m_arvalid | bus.m_awvalid;
  assign busy = state != IDLE;
  assign g_inc = (int'(grant_id) == NUM_MASTERS - 1) ? '0 : grant_id + 1'b1;
  assign bus.m_rdata = {NUM_MASTERS{bus.s_rdata}};
  assign bus.m_rresp = {NUM_MASTERS{bus.s_rresp}};
  assign bus.m_bresp = {NUM_MASTERS{bus.s_bresp}};
  assign bus.s_araddr = bus.m_araddr[int'(grant_id)*ADDR_W +: ADDR_W];
  assign bus.s_awaddr = bus.m_awaddr[int'(grant_id)*ADDR_W +: ADDR_W];
  assign bus.s_wdata = bus.m_wdata[int'(grant_id)*DATA_W +: DATA_W];
  assign bus.s_wstrb = bus.m_wstrb[int'(grant_id)*STRB_W +: STRB_W];
  // Round-robin search from ptr; walking offsets downward leaves the nearest requester as winner
  always_comb begin
    win = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--)
      if (req[(int'(ptr) + i) % NUM_MASTERS]) win = GW'((int'(ptr) + i) % NUM_MASTERS);
  end
  // State, owner, fairness pointer and write-progress registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      ptr <= '0;
      grant_id <= '0;
      aw_done <= 1'b0;
      w_done <= 1'b0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      grant_id <= grant_n;
      aw_done <= aw_n;
      w_done <= w_n;
    end
  end
  // Next state and combinational forwarding of the owner's handshakes
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    grant_n = grant_id;
    aw_n = aw_done;
    w_n = w_done;
    bus.s_arvalid = 1'b0;
    bus.s_rready = 1'b0;
    bus.s_awvalid = 1'b0;
    bus.s_wvalid = 1'b0;
    bus.s_bready = 1'b0;
    bus.m_arready = '0;
    bus.m_rvalid = '0;
    bus.m_awready = '0;
    bus.m_wready = '0;
    bus.m_bvalid = '0;
    case (state)
      IDLE: if (|req) begin
        grant_n = win;
        state_n = bus.m_arvalid[win] ? RD_ADDR : WR;
      end
      RD_ADDR: begin
        bus.s_arvalid = bus.m_arvalid[grant_id];
        bus.m_arready[grant_id] = bus.s_arready;
        if (bus.m_arvalid[grant_id] && bus.s_arready) state_n = RD_DATA;
      end
      RD_DATA: begin
        bus.m_rvalid[grant_id] = bus.s_rvalid;
        bus.s_rready = bus.m_rready[grant_id];
        if (bus.s_rvalid && bus.m_rready[grant_id]) begin
          state_n = IDLE;
          ptr_n = g_inc;
        end
      end
      WR: begin
        bus.s_awvalid = bus.m_awvalid[grant_id] & ~aw_done;
        bus.m_awready[grant_id] = bus.s_awready & ~aw_done;
        bus.s_wvalid = bus.m_wvalid[grant_id] & ~w_done;
        bus.m_wready[grant_id] = bus.s_wready & ~w_done;
        aw_n = aw_done | (bus.m_awvalid[grant_id] & bus.s_awready);
        w_n = w_done | (bus.m_wvalid[grant_id] & bus.s_wready);
        if (aw_n && w_n) state_n = WR_RESP;
      end
      WR_RESP: begin
        bus.m_bvalid[grant_id] = bus.s_bvalid;
        bus.s_bready = bus.m_bready[grant_id];
        if (bus.s_bvalid && bus.m_bready[grant_id]) begin
          state_n = IDLE;
          ptr_n = g_inc;
          aw_n = 1'b0;
          w_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_axi_rr_arbiter.sv
// tb_axi_rr_arbiter: directed scoreboard bench for the 3-master round-robin arbiter
module tb_axi_rr_arbiter;
  typedef struct {int m; logic [31:0] a; logic [31:0] d;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0] grant_id;
  logic busy;
  logic busy_q = 1'b0;
  logic keep_ar = 1'b1;
  logic aw_seen, w_seen;
  logic [31:0] last_araddr, last_awaddr, last_wdata;
  logic [3:0] last_wstrb;
  int aw_cnt = 0;
  int w_cnt = 0;
  int r_cnt = 0;
  int compared = 0;
  int mism = 0;
  exp_t rq[$];
  exp_t bq[$];
  int gq[$];
  axi_rr_arbiter_if #(.NUM_MASTERS(3), .ADDR_W(32), .DATA_W(32)) bus ();
  axi_rr_arbiter #(.NUM_MASTERS(3), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .bus(bus), .grant_id(grant_id), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    logic [2:0] har, haw, hw;
    @(negedge clk);
    har = bus.m_arvalid & bus.m_arready;
    haw = bus.m_awvalid & bus.m_awready;
    hw = bus.m_wvalid & bus.m_wready;
    @(posedge clk);
    #1;
    if (!keep_ar) bus.m_arvalid &= ~har;
    bus.m_awvalid &= ~haw;
    bus.m_wvalid &= ~hw;
  endtask
  task automatic drain(input string tag);
    int c = 0;
    while ((gq.size() + rq.size() + bq.size() != 0 || busy) && c < 60) begin
      tick();
      c++;
    end
    chk(tag, 64'(gq.size() + rq.size() + bq.size()) + 64'(busy), 0);
  endtask
  // Slave model: always ready for AR/AW/W, returns R one cycle after AR and B once AW and W are both seen
  always @(posedge clk) begin
    if (!rst) begin
      bus.s_rvalid <= 1'b0;
      bus.s_bvalid <= 1'b0;
      aw_seen <= 1'b0;
      w_seen <= 1'b0;
    end else begin
      if (bus.s_arvalid && bus.s_arready) begin
        bus.s_rvalid <= 1'b1;
        last_araddr <= bus.s_araddr;
      end else if (bus.s_rvalid && bus.s_rready) bus.s_rvalid <= 1'b0;
      if (bus.s_awvalid && bus.s_awready) begin
        aw_seen <= 1'b1;
        aw_cnt <= aw_cnt + 1;
        last_awaddr <= bus.s_awaddr;
      end
      if (bus.s_wvalid && bus.s_wready) begin
        w_seen <= 1'b1;
        w_cnt <= w_cnt + 1;
        last_wdata <= bus.s_wdata;
        last_wstrb <= bus.s_wstrb;
      end
      if (bus.s_bvalid && bus.s_bready) bus.s_bvalid <= 1'b0;
      else if (aw_seen && w_seen) begin
        bus.s_bvalid <= 1'b1;
        aw_seen <= 1'b0;
        w_seen <= 1'b0;
      end
    end
  end
  // Monitor: ownership of ready/valid, grant order, and R/B results popped from the scoreboard
  always @(negedge clk) begin : mon
    exp_t e;
    logic [2:0] own;
    if (rst) begin
      own = busy ? 3'(3'b001 << grant_id) : 3'b000;
      chk("owner_only", 64'((bus.m_rvalid | bus.m_bvalid | bus.m_arready | bus.m_awready | bus.m_wready) & ~own), 0);
      if (busy && !busy_q) begin
        chk("grant_expected", 64'(gq.size() != 0), 1);
        if (gq.size() != 0) chk("grant_id", 64'(grant_id), 64'(gq.pop_front()));
      end
      for (int i = 0; i < 3; i++) begin
        if (bus.m_rvalid[i] && bus.m_rready[i]) begin
          r_cnt <= r_cnt + 1;
          chk("r_expected", 64'(rq.size() != 0), 1);
          if (rq.size() != 0) begin
            e = rq.pop_front();
            chk("r_master", 64'(i), 64'(e.m));
            chk("r_addr", 64'(last_araddr), 64'(e.a));
            chk("r_data", 64'(bus.m_rdata[i*32 +: 32]), 64'(e.d));
          end
        end
        if (bus.m_bvalid[i] && bus.m_bready[i]) begin
          chk("b_expected", 64'(bq.size() != 0), 1);
          if (bq.size() != 0) begin
            e = bq.pop_front();
            chk("b_master", 64'(i), 64'(e.m));
            chk("b_resp", 64'(bus.m_bresp[i*2 +: 2]), 64'(e.d));
          end
        end
      end
    end
    busy_q <= busy;
  end
  initial begin
    bus.m_araddr = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000};
    bus.m_arvalid = 3'b111;
    bus.m_rready = 3'b111;
    bus.m_awaddr = '0;
    bus.m_awvalid = 3'b000;
    bus.m_wdata = '0;
    bus.m_wstrb = '0;
    bus.m_wvalid = 3'b000;
    bus.m_bready = 3'b111;
    bus.s_arready = 1'b1;
    bus.s_awready = 1'b1;
    bus.s_wready = 1'b1;
    bus.s_rdata = 32'hDEAD_BEEF;
    bus.s_rresp = 2'b00;
    bus.s_bresp = 2'b00;
    tick();
    tick();
    chk("rst_busy", 64'(busy), 0);
    chk("rst_s_valids", {61'b0, bus.s_arvalid, bus.s_awvalid, bus.s_wvalid}, 0);
    chk("rst_s_readys", {62'b0, bus.s_rready, bus.s_bready}, 0);
    chk("rst_m_readys", 64'({bus.m_arready, bus.m_awready, bus.m_wready}), 0);
    chk("rst_m_valids", 64'({bus.m_rvalid, bus.m_bvalid}), 0);
    chk("rst_grant", 64'(grant_id), 0);
    gq.push_back(0); gq.push_back(1); gq.push_back(2); gq.push_back(0);
    rq.push_back('{0, 32'h1000_0000, 32'hDEAD_BEEF});
    rq.push_back('{1, 32'h2000_0000, 32'hDEAD_BEEF});
    rq.push_back('{2, 32'h3000_0000, 32'hDEAD_BEEF});
    rq.push_back('{0, 32'h1000_0000, 32'hDEAD_BEEF});
    rst = 1'b1;
    tick();
    chk("release_grant", 64'(grant_id), 0);
    chk("release_busy", 64'(busy), 1);
    chk("fwd_arvalid", 64'(bus.s_arvalid), 1);
    chk("fwd_araddr", 64'(bus.s_araddr), 64'h1000_0000);
    for (int c = 0; c < 60 && r_cnt < 4; c++) tick();
    chk("contention_reads", 64'(r_cnt), 4);
    bus.m_arvalid = 3'b000;
    keep_ar = 1'b0;
    gq.push_back(1);
    rq.push_back('{1, 32'h8000_0004, 32'hDEAD_BEEF});
    bus.m_araddr[32 +: 32] = 32'h8000_0004;
    bus.m_arvalid = 3'b010;
    drain("single_read_done");
    gq.push_back(2);
    bq.push_back('{2, 32'h0, 32'h0});
    bus.m_awaddr[64 +: 32] = 32'h4000_0010;
    bus.m_wdata[64 +: 32] = 32'h1234_5678;
    bus.m_wstrb[8 +: 4] = 4'hF;
    bus.m_awvalid = 3'b100;
    tick();
    chk("wr_fwd_awvalid", 64'(bus.s_awvalid), 1);
    chk("wr_fwd_awaddr", 64'(bus.s_awaddr), 64'h4000_0010);
    tick();
    chk("wr_aw_once", 64'(aw_cnt), 1);
    chk("wr_aw_masked", 64'(bus.s_awvalid), 0);
    tick();
    chk("wr_w_pending", 64'(w_cnt), 0);
    bus.m_wvalid = 3'b100;
    drain("split_write_done");
    chk("split_aw_cnt", 64'(aw_cnt), 1);
    chk("split_w_cnt", 64'(w_cnt), 1);
    chk("split_awaddr", 64'(last_awaddr), 64'h4000_0010);
    chk("split_wdata", 64'(last_wdata), 64'h1234_5678);
    chk("split_wstrb", 64'(last_wstrb), 64'hF);
    gq.push_back(0);
    bq.push_back('{0, 32'h0, 32'h2});
    bus.s_bresp = 2'b10;
    bus.m_awaddr[0 +: 32] = 32'h5000_0020;
    bus.m_wdata[0 +: 32] = 32'hA5A5_0F0F;
    bus.m_wstrb[0 +: 4] = 4'h3;
    bus.m_awvalid = 3'b001;
    bus.m_wvalid = 3'b001;
    drain("joint_write_done");
    chk("joint_aw_cnt", 64'(aw_cnt), 2);
    chk("joint_w_cnt", 64'(w_cnt), 2);
    chk("joint_awaddr", 64'(last_awaddr), 64'h5000_0020);
    chk("joint_wdata", 64'(last_wdata), 64'hA5A5_0F0F);
    chk("joint_wstrb", 64'(last_wstrb), 64'h3);
    bus.s_bresp = 2'b00;
    bus.s_rdata = 32'h0BAD_F00D;
    gq.push_back(1); gq.push_back(0); gq.push_back(1);
    rq.push_back('{1, 32'h6000_0000, 32'h0BAD_F00D});
    rq.push_back('{0, 32'h7000_0000, 32'h0BAD_F00D});
    bq.push_back('{1, 32'h0, 32'h0});
    bus.m_araddr[0 +: 32] = 32'h7000_0000;
    bus.m_araddr[32 +: 32] = 32'h6000_0000;
    bus.m_awaddr[32 +: 32] = 32'h6000_0040;
    bus.m_wdata[32 +: 32] = 32'hCAFE_F00D;
    bus.m_wstrb[4 +: 4] = 4'hF;
    bus.m_arvalid = 3'b011;
    bus.m_awvalid = 3'b010;
    bus.m_wvalid = 3'b010;
    drain("rd_before_wr_done");
    chk("rw_aw_cnt", 64'(aw_cnt), 3);
    chk("rw_awaddr", 64'(last_awaddr), 64'h6000_0040);
    chk("rw_wdata", 64'(last_wdata), 64'hCAFE_F00D);
    gq.push_back(2);
    bus.m_araddr[64 +: 32] = 32'h9000_0000;
    bus.m_rready = 3'b011;
    bus.m_arvalid = 3'b100;
    tick();
    tick();
    chk("rd_data_busy", 64'(busy), 1);
    chk("rd_data_rvalid", 64'(bus.m_rvalid), 64'b100);
    rst = 1'b0;
    tick();
    chk("midrst_busy", 64'(busy), 0);
    chk("midrst_rvalid", 64'(bus.m_rvalid), 0);
    chk("midrst_grant", 64'(grant_id), 0);
    rst = 1'b1;
    bus.m_rready = 3'b111;
    tick();
    chk("post_rst_idle", 64'(busy), 0);
    gq.push_back(1); gq.push_back(2);
    rq.push_back('{1, 32'h6000_0000, 32'h0BAD_F00D});
    rq.push_back('{2, 32'h9000_0000, 32'h0BAD_F00D});
    bus.m_arvalid = 3'b110;
    drain("ptr_reset_done");
    chk("scoreboard_empty", 64'(gq.size() + rq.size() + bq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end
endmodule
